// File: rtl/adventure_status.sv
// adventure_status: tracks the player's room sequence from the room-navigation
// stage, counts accepted room changes, records sword pickup and resolves the
// game into WON or LOST when the dragon room (DD) is entered.
// Optional feature: define ADV_MOVE_LIMIT_EN to add the move-limit loss rule
// (the player loses when move_count reaches MOVE_LIMIT).
//
// state | meaning
// ------+----------------------------------------------------------
// PLAY  | game in progress; room changes counted, sword can be taken
// WON   | entered DD holding the sword; terminal until Reset
// LOST  | entered DD without the sword (or hit move limit); terminal
module adventure_status #(
  parameter int unsigned MOVE_LIMIT = 32
) (
  input  logic       CLK,
  input  logic       Reset,
  input  logic [2:0] rooms,
  output logic       sword,
  output logic       win,
  output logic       dead,
  output logic       game_over,
  output logic       room_changed,
  output logic [7:0] move_count
);

  localparam logic [2:0] ROOM_CC  = 3'b000;
  localparam logic [2:0] ROOM_SSS = 3'b100;
  localparam logic [2:0] ROOM_DD  = 3'b110;
  localparam logic [7:0] COUNT_MAX = 8'hFF;

  // MOVE_LIMIT outside 1..255 cannot be reached by an 8-bit saturating count
  if (MOVE_LIMIT < 1 || MOVE_LIMIT > 255) begin : g_bad_move_limit
    $error("adventure_status: MOVE_LIMIT must be in 1..255");
  end

  typedef enum logic [1:0] {
    PLAY = 2'd0,
    WON  = 2'd1,
    LOST = 2'd2
  } state_t;

  state_t     state_q, state_d;
  logic [2:0] prev_room_q, prev_room_d;
  logic       sword_q, sword_d;
  logic       room_changed_q, room_changed_d;
  logic [7:0] move_count_q, move_count_d;
  logic       win_q, win_d;
  logic       dead_q, dead_d;
  logic       game_over_q, game_over_d;
  logic       change;

  // Next-state and next-output computation; terminal states hold everything
  always_comb begin
    state_d        = state_q;
    prev_room_d    = prev_room_q;
    sword_d        = sword_q;
    room_changed_d = 1'b0;
    move_count_d   = move_count_q;
    change         = 1'b0;

    if (state_q == PLAY) begin
      change         = (rooms != prev_room_q);
      room_changed_d = change;
      prev_room_d    = rooms;
      if (change && (move_count_q != COUNT_MAX)) begin
        move_count_d = move_count_q + 8'd1;
      end
      if (rooms == ROOM_SSS) begin
        sword_d = 1'b1;
      end
      // Entering DD resolves the game on the sword already held; win wins ties
      if (rooms == ROOM_DD) begin
        state_d = sword_q ? WON : LOST;
      end
`ifdef ADV_MOVE_LIMIT_EN
      else if (change && (move_count_d == 8'(MOVE_LIMIT))) begin
        state_d = LOST;
      end
`endif
    end

    win_d       = (state_d == WON);
    dead_d      = (state_d == LOST);
    game_over_d = win_d | dead_d;
  end

  // State and output registers with synchronous reset
  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_q        <= PLAY;
      prev_room_q    <= ROOM_CC;
      sword_q        <= 1'b0;
      room_changed_q <= 1'b0;
      move_count_q   <= 8'd0;
      win_q          <= 1'b0;
      dead_q         <= 1'b0;
      game_over_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      prev_room_q    <= prev_room_d;
      sword_q        <= sword_d;
      room_changed_q <= room_changed_d;
      move_count_q   <= move_count_d;
      win_q          <= win_d;
      dead_q         <= dead_d;
      game_over_q    <= game_over_d;
    end
  end

  assign sword        = sword_q;
  assign win          = win_q;
  assign dead         = dead_q;
  assign game_over    = game_over_q;
  assign room_changed = room_changed_q;
  assign move_count   = move_count_q;

endmodule

// File: tb/tb_adventure_status.sv
// Testbench for adventure_status: a behavioural game model predicts each
// cycle's outputs, pushes them to a queue when stimulus is driven, and the
// prediction is popped and compared after the following posedge.
module tb_adventure_status;

  localparam logic [2:0] CC = 3'b000, TT = 3'b001, RR = 3'b101, SSS = 3'b100,
                         DD = 3'b110, GG = 3'b011, VV = 3'b111;
  localparam int LIMIT = 4;
`ifdef ADV_MOVE_LIMIT_EN
  localparam bit LIMIT_EN = 1'b1;
`else
  localparam bit LIMIT_EN = 1'b0;
`endif

  logic       CLK = 1'b0;
  logic       Reset = 1'b1;
  logic [2:0] rooms = CC;
  logic       sword, win, dead, game_over, room_changed;
  logic [7:0] move_count;

  adventure_status #(.MOVE_LIMIT(LIMIT)) dut (
    .CLK(CLK), .Reset(Reset), .rooms(rooms), .sword(sword), .win(win),
    .dead(dead), .game_over(game_over), .room_changed(room_changed),
    .move_count(move_count)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic       sword;
    logic       win;
    logic       dead;
    logic       game_over;
    logic       room_changed;
    logic [7:0] move_count;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0;
  int failures = 0;
  int pulses = 0;

  // model state: 0 = playing, 1 = won, 2 = lost
  int         m_state;
  logic [2:0] m_prev;
  logic       m_sword;
  logic       m_rc;
  int         m_cnt;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, want, $time);
    end
  endtask

  task automatic model(input logic rst, input logic [2:0] r);
    bit chg;
    int nxt;
    if (rst) begin
      m_state = 0; m_prev = CC; m_sword = 0; m_rc = 0; m_cnt = 0;
    end else if (m_state == 0) begin
      chg = (r != m_prev);
      m_rc = chg;
      if (chg && m_cnt < 255) m_cnt++;
      nxt = 0;
      if (r == DD) nxt = m_sword ? 1 : 2;
      else if (LIMIT_EN && chg && m_cnt == LIMIT) nxt = 2;
      if (r == SSS) m_sword = 1;
      m_prev = r;
      m_state = nxt;
    end else begin
      m_rc = 0;
    end
  endtask

  task automatic step(input logic rst, input logic [2:0] r);
    exp_t e, p;
    @(negedge CLK);
    Reset = rst;
    rooms = r;
    model(rst, r);
    e.sword = m_sword;
    e.win = (m_state == 1);
    e.dead = (m_state == 2);
    e.game_over = (m_state != 0);
    e.room_changed = m_rc;
    e.move_count = 8'(m_cnt);
    exp_q.push_back(e);
    @(posedge CLK);
    #1;
    if (exp_q.size() == 0) begin
      chk("queue_empty", 32'd1, 32'd0);
    end else begin
      p = exp_q.pop_front();
      chk("sword", 32'(sword), 32'(p.sword));
      chk("win", 32'(win), 32'(p.win));
      chk("dead", 32'(dead), 32'(p.dead));
      chk("game_over", 32'(game_over), 32'(p.game_over));
      chk("room_changed", 32'(room_changed), 32'(p.room_changed));
      chk("move_count", 32'(move_count), 32'(p.move_count));
    end
    pulses += int'(room_changed);
  endtask

  task automatic hold(input logic [2:0] r, input int n);
    for (int i = 0; i < n; i++) step(1'b0, r);
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) step(1'b1, CC);
  endtask

  initial begin
    // Reset state
    do_reset(2);
    chk("rst_move_count", 32'(move_count), 32'd0);
    chk("rst_game_over", 32'(game_over), 32'd0);

    // CC->TT->RR->SSS, two cycles each
    pulses = 0;
    hold(CC, 2); hold(TT, 2); hold(RR, 1);
    chk("sword_before_sss", 32'(sword), 32'd0);
    hold(RR, 1); hold(SSS, 1);
    chk("sword_after_sss", 32'(sword), 32'd1);
    hold(SSS, 1);
    chk("walk_count", 32'(move_count), 32'd3);
    chk("walk_pulses", 32'(pulses), 32'd3);

    // Into DD with sword: win, then everything frozen
    hold(DD, 1);
    chk("win_dd", 32'(win), 32'd1);
    chk("win_dead", 32'(dead), 32'd0);
    chk("win_count", 32'(move_count), 32'd4);
    hold(TT, 2); hold(GG, 1); hold(VV, 1); hold(SSS, 1); hold(DD, 1);
    chk("frozen_count", 32'(move_count), 32'd4);
    chk("frozen_win", 32'(win), 32'd1);

    // One reset cycle while won; rooms held CC afterwards gives no pulse
    do_reset(1);
    chk("rst_win", 32'(win), 32'd0);
    pulses = 0;
    hold(CC, 3);
    chk("cc_no_pulse", 32'(pulses), 32'd0);

    // CC->TT->DD without sword: lose
    hold(TT, 1); hold(DD, 2);
    chk("lose_dead", 32'(dead), 32'd1);
    chk("lose_count", 32'(move_count), 32'd2);

    // Rooms ignored while Reset held; first edge after compares against CC
    step(1'b1, TT); step(1'b1, SSS); step(1'b1, DD);
    chk("held_rst_sword", 32'(sword), 32'd0);
    hold(TT, 1);
    chk("first_after_rst", 32'(room_changed), 32'd1);

    // Four non-DD changes using GG/VV: move-limit loss only when compiled in
    do_reset(1);
    hold(GG, 1); hold(VV, 1); hold(GG, 1); hold(TT, 1);
    chk("limit_dead", 32'(dead), 32'(LIMIT_EN));
    chk("limit_sword", 32'(sword), 32'd0);
    hold(CC, 1);
    chk("limit_count5", 32'(move_count), LIMIT_EN ? 32'd4 : 32'd5);

    // Fourth change into DD holding the sword: win beats the limit
    do_reset(1);
    hold(TT, 1); hold(RR, 1); hold(SSS, 1); hold(DD, 1);
    chk("limit_win", 32'(win), 32'd1);
    chk("limit_win_dead", 32'(dead), 32'd0);

    // 300 alternating changes: saturation when no limit
    do_reset(1);
    for (int i = 0; i < 300; i++) step(1'b0, (i % 2 == 0) ? TT : CC);
    chk("sat_count", 32'(move_count), LIMIT_EN ? 32'd4 : 32'd255);
    chk("sat_dead", 32'(dead), 32'(LIMIT_EN));

    // Random rooms with occasional resets
    do_reset(1);
    for (int i = 0; i < 250; i++) begin
      step(($urandom_range(0, 39) == 0), 3'($urandom_range(0, 7)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
